mmio_trace_buf: RTL and testbench
=================================

Name: mmio_trace_buf

Overview:
- Synthesizable MMIO write tracer: snoops the CPU-side MMIO write bus (addr/data/mask/wren) and captures qualifying writes into a parametrised FIFO of trace records.
- Records drain through a valid/ready port (UART dumper, debug bridge, or bench checker).
- Generalises simple print-on-write monitoring: address window filter, configurable depth, stop-on-full or overwrite-oldest modes, drop counter and optional timestamps.

Parameters:
- ADDR_W, 30, MMIO word-address width.
- DATA_W, 32, MMIO data width; mask width is DATA_W/8.
- DEPTH, 16, FIFO entries; power of two, >= 2.
- TS_W, 16, timestamp width.
- WIN_LO, 0, lowest captured word address (inclusive).
- WIN_HI, 2**30-1, highest captured word address (inclusive).
- OVERWRITE, 0, 0 = drop new write when full; 1 = discard oldest entry and keep new.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_mmio_addr  in  ADDR_W  snooped word address.
- i_mmio_data  in  DATA_W  snooped write data.
- i_mmio_mask  in  DATA_W/8  snooped byte-enable mask.
- i_mmio_wren  in  1  snooped write strobe.
- i_enable  in  1  capture enable.
- i_clear  in  1  synchronous flush.
- o_rec_valid  out  1  head record available.
- i_rec_ready  in  1  consumer accepts head record.
- o_rec_addr  out  ADDR_W  head record address.
- o_rec_data  out  DATA_W  head record data.
- o_rec_mask  out  DATA_W/8  head record mask.
- o_rec_ts  out  TS_W  head record timestamp.
- o_count  out  $clog2(DEPTH)+1  entries held.
- o_full  out  1  count == DEPTH.
- o_drop_cnt  out  16  lost-record counter, saturating.

Behaviour:
- Reset (rst_n low, asynchronous):
  - o_rec_valid = 0, o_count = 0, o_full = 0, o_drop_cnt = 0.
  - Pointers and timestamp counter = 0.
  - o_rec_addr/data/mask/ts = 0 while empty.
  - Storage contents are not reset.
- Capture condition (push): i_mmio_wren & i_enable & (i_mmio_mask != 0) & WIN_LO <= i_mmio_addr <= WIN_HI, sampled at posedge clk.
- Record content: {addr, data, mask, ts}, where ts = timestamp counter value in the capture cycle.
- Latency: push on edge N -> o_rec_valid = 1 and fields valid after edge N (one cycle), when the FIFO was empty.
- Output fields always show the oldest entry; they are stable while o_rec_valid & !i_rec_ready.
- Pop: o_rec_valid & i_rec_ready at posedge; next entry presented the following cycle.
- Simultaneous push + pop: accepted at any count, including full; count unchanged; no drop.
- Push while full, no pop:
  - OVERWRITE = 0: new write discarded; o_drop_cnt += 1.
  - OVERWRITE = 1: oldest entry discarded (head advances), new entry written at tail; count stays DEPTH; o_drop_cnt += 1.
- o_drop_cnt saturates at 16'hFFFF.
- Pointers: $clog2(DEPTH) bits, wrap modulo DEPTH; full/empty come from the count register, not pointer equality.
- Timestamp: free-running TS_W counter, +1 every cycle, wraps to 0.
- i_clear (synchronous) sets, on the next edge:
  - count, pointers, o_drop_cnt and timestamp to 0; o_rec_valid to 0.
  - i_clear overrides any same-cycle push or pop; a capture coinciding with i_clear is lost and not counted.
- i_enable low: no pushes, no drops counted; draining continues normally.
- Reset mid-drain: all state cleared immediately; the consumer sees o_rec_valid fall asynchronously.

Optional Feature:
- Macro MMIO_TRACE_TS_EN.
- Defined: timestamp counter present; records carry the capture-cycle timestamp.
- Undefined: counter and timestamp storage removed; o_rec_ts tied to 0; port list unchanged.

Test Plan:
- Basic capture: after reset, write addr 30'h10, data 32'hDEADBEEF, mask 4'b1111 with ready = 0 -> next cycle o_rec_valid = 1, fields match, o_count = 1; ready = 1 for one cycle -> o_count = 0, o_rec_valid = 0.
- Filter: WIN_LO = 30'h100, WIN_HI = 30'h1FF; writes to 30'hFF, 30'h100, 30'h1FF, 30'h200, plus a write with mask 4'b0000 inside the window -> exactly two records (0x100, 0x1FF), in order.
- Stop-on-full: DEPTH = 4, OVERWRITE = 0, ready = 0, six writes with data 1..6 -> o_full = 1, o_drop_cnt = 2, drain yields 1, 2, 3, 4.
- Overwrite: DEPTH = 4, OVERWRITE = 1, same stimulus -> o_drop_cnt = 2, drain yields 3, 4, 5, 6; with TS_EN defined, timestamps strictly increasing by 1 for back-to-back writes.
- Full with simultaneous push/pop: fill to 4, then write data 7 with ready = 1 in the same cycle -> o_count stays 4, o_drop_cnt unchanged, 7 is last out.
- Clear/reset: fill 3 entries, assert i_clear together with a write -> next cycle o_count = 0, o_drop_cnt = 0, no record; fill 2 more, drop rst_n mid-drain -> outputs are 0 immediately.

Source files
------------

// File: rtl/mmio_trace_buf.sv
// MMIO write tracer: snoops qualifying bus writes into a DEPTH-entry record FIFO drained over valid/ready.
// Optional timestamps are enabled by defining MMIO_TRACE_TS_EN; otherwise o_rec_ts is tied to 0.
module mmio_trace_buf #(
  parameter int                ADDR_W    = 30,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 16,
  parameter int                TS_W      = 16,
  parameter logic [ADDR_W-1:0] WIN_LO    = '0,
  parameter logic [ADDR_W-1:0] WIN_HI    = '1,
  parameter bit                OVERWRITE = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_W-1:0]          i_mmio_addr,
  input  logic [DATA_W-1:0]          i_mmio_data,
  input  logic [DATA_W/8-1:0]        i_mmio_mask,
  input  logic                       i_mmio_wren,
  input  logic                       i_enable,
  input  logic                       i_clear,
  output logic                       o_rec_valid,
  input  logic                       i_rec_ready,
  output logic [ADDR_W-1:0]          o_rec_addr,
  output logic [DATA_W-1:0]          o_rec_data,
  output logic [DATA_W/8-1:0]        o_rec_mask,
  output logic [TS_W-1:0]            o_rec_ts,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic [15:0]                o_drop_cnt
);

  localparam int MASK_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  logic [ADDR_W-1:0] mem_addr_q [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [MASK_W-1:0] mem_mask_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      drop_q, drop_d;
  logic             lo_ok, hi_ok, push, pop, full, wr_en;

  // Window bounds at the extremes of the address range need no comparator.
  if (WIN_LO == '0) begin : g_lo_all
    assign lo_ok = 1'b1;
  end else begin : g_lo
    assign lo_ok = (i_mmio_addr >= WIN_LO);
  end
  if (WIN_HI == '1) begin : g_hi_all
    assign hi_ok = 1'b1;
  end else begin : g_hi
    assign hi_ok = (i_mmio_addr <= WIN_HI);
  end

  assign push = i_mmio_wren & i_enable & (|i_mmio_mask) & lo_ok & hi_ok;
  assign full = (count_q == CNT_W'(DEPTH));
  assign pop  = (count_q != '0) & i_rec_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    drop_d  = drop_q;
    wr_en   = 1'b0;
    if (i_clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      drop_d  = '0;
    end else begin
      // When full in overwrite mode tail == head, so the new write lands on the oldest slot.
      if (push && (pop || !full || OVERWRITE)) begin
        wr_en  = 1'b1;
        tail_d = tail_q + PTR_W'(1);
      end
      if (pop || (push && full && OVERWRITE)) begin
        head_d = head_q + PTR_W'(1);
      end
      if (push && full && !pop && (drop_q != 16'hFFFF)) begin
        drop_d = drop_q + 16'd1;
      end
      if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end else if (push && !pop && !full) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_addr_q[tail_q] <= i_mmio_addr;
      mem_data_q[tail_q] <= i_mmio_data;
      mem_mask_q[tail_q] <= i_mmio_mask;
    end
  end

`ifdef MMIO_TRACE_TS_EN
  logic [TS_W-1:0] ts_q, ts_d;
  logic [TS_W-1:0] mem_ts_q [DEPTH];

  always_comb begin
    ts_d = i_clear ? '0 : ts_q + TS_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_ts_q[tail_q] <= ts_q;
  end

  assign o_rec_ts = o_rec_valid ? mem_ts_q[head_q] : '0;
`else
  assign o_rec_ts = '0;
`endif

  // Storage is never reset, so fields are gated to zero whenever the FIFO is empty.
  assign o_rec_valid = (count_q != '0);
  assign o_rec_addr  = o_rec_valid ? mem_addr_q[head_q] : '0;
  assign o_rec_data  = o_rec_valid ? mem_data_q[head_q] : '0;
  assign o_rec_mask  = o_rec_valid ? mem_mask_q[head_q] : '0;
  assign o_count     = count_q;
  assign o_full      = full;
  assign o_drop_cnt  = drop_q;

endmodule

// File: tb/tb_mmio_trace_buf.sv
// Bench for mmio_trace_buf: three instances (stop-on-full, overwrite, windowed) share one stimulus
// and are compared against a queue-based reference model plus directed constant checks.
module tb_mmio_trace_buf;

  localparam int N       = 3;
  localparam int M_DEPTH = 4;

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    logic [15:0] t;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [29:0] addr;
  logic [31:0] data;
  logic [3:0]  mask;
  logic        wren, en, clr, rdy;

  logic        v    [N];
  logic [29:0] ra   [N];
  logic [31:0] rd   [N];
  logic [3:0]  rm   [N];
  logic [15:0] rt   [N];
  logic [2:0]  cnt  [N];
  logic        full [N];
  logic [15:0] drp  [N];

  int errors = 0;
  int checks = 0;

  rec_t        mq [N][$];
  int          mdrop [N];
  logic [15:0] ts_m;
  int          m_ow [N] = '{0, 1, 0};
  int unsigned m_lo [N] = '{0, 0, 'h100};
  int unsigned m_hi [N] = '{'h3FFF_FFFF, 'h3FFF_FFFF, 'h1FF};

  always #5 clk = ~clk;

  mmio_trace_buf #(.DEPTH(4), .OVERWRITE(1'b0)) u_stop (
    .clk(clk), .rst_n(rst_n), .i_mmio_addr(addr), .i_mmio_data(data), .i_mmio_mask(mask),
    .i_mmio_wren(wren), .i_enable(en), .i_clear(clr), .o_rec_valid(v[0]), .i_rec_ready(rdy),
    .o_rec_addr(ra[0]), .o_rec_data(rd[0]), .o_rec_mask(rm[0]), .o_rec_ts(rt[0]),
    .o_count(cnt[0]), .o_full(full[0]), .o_drop_cnt(drp[0]));

  mmio_trace_buf #(.DEPTH(4), .OVERWRITE(1'b1)) u_ovw (
    .clk(clk), .rst_n(rst_n), .i_mmio_addr(addr), .i_mmio_data(data), .i_mmio_mask(mask),
    .i_mmio_wren(wren), .i_enable(en), .i_clear(clr), .o_rec_valid(v[1]), .i_rec_ready(rdy),
    .o_rec_addr(ra[1]), .o_rec_data(rd[1]), .o_rec_mask(rm[1]), .o_rec_ts(rt[1]),
    .o_count(cnt[1]), .o_full(full[1]), .o_drop_cnt(drp[1]));

  mmio_trace_buf #(.DEPTH(4), .WIN_LO(30'h100), .WIN_HI(30'h1FF)) u_win (
    .clk(clk), .rst_n(rst_n), .i_mmio_addr(addr), .i_mmio_data(data), .i_mmio_mask(mask),
    .i_mmio_wren(wren), .i_enable(en), .i_clear(clr), .o_rec_valid(v[2]), .i_rec_ready(rdy),
    .o_rec_addr(ra[2]), .o_rec_data(rd[2]), .o_rec_mask(rm[2]), .o_rec_ts(rt[2]),
    .o_count(cnt[2]), .o_full(full[2]), .o_drop_cnt(drp[2]));

  function automatic logic [15:0] exp_ts(input rec_t r);
`ifdef MMIO_TRACE_TS_EN
    return r.t;
`else
    return 16'h0;
`endif
  endfunction

  // Advance the reference model by one edge using the inputs the DUT is about to sample.
  task automatic cycle();
    rec_t r;
    bit   push, pop;
    for (int i = 0; i < N; i++) begin
      push = wren && en && (mask != 4'h0) && (addr >= m_lo[i]) && (addr <= m_hi[i]);
      pop  = (mq[i].size() != 0) && rdy;
      if (clr) begin
        mq[i].delete();
        mdrop[i] = 0;
      end else begin
        if (pop) void'(mq[i].pop_front());
        if (push) begin
          r.a = addr; r.d = data; r.m = mask; r.t = ts_m;
          if (mq[i].size() < M_DEPTH) begin
            mq[i].push_back(r);
          end else begin
            if (m_ow[i] != 0) begin
              void'(mq[i].pop_front());
              mq[i].push_back(r);
            end
            if (mdrop[i] < 65535) mdrop[i]++;
          end
        end
      end
    end
    ts_m = clr ? 16'h0 : ts_m + 16'h1;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
    addr = a; data = d; mask = m; wren = 1'b1;
    cycle();
    wren = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    wren = 1'b0; clr = 1'b0; rdy = 1'b0; en = 1'b1;
    addr = '0; data = '0; mask = '0;
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      mdrop[i] = 0;
    end
    ts_m = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < N; i++) begin
      checks++;
      if ({v[i], cnt[i], full[i], drp[i], ra[i], rd[i], rm[i], rt[i]} !== '0) begin
        errors++;
        $display("FAIL reset_state inst=%0d got v=%b cnt=%0d full=%b drop=%0d addr=%h data=%h mask=%h ts=%h required all zero",
                 i, v[i], cnt[i], full[i], drp[i], ra[i], rd[i], rm[i], rt[i]);
      end
    end
  endtask

  task automatic test_basic();
    logic [15:0] t0;
    apply_reset();
    t0 = ts_m;
    wr(30'h10, 32'hDEADBEEF, 4'hF);
    checks++;
    if ({v[0], ra[0], rd[0], rm[0], cnt[0]} !== {1'b1, 30'h10, 32'hDEADBEEF, 4'hF, 3'd1}) begin
      errors++;
      $display("FAIL basic_capture got v=%b addr=%h data=%h mask=%h cnt=%0d required 1/10/deadbeef/f/1",
               v[0], ra[0], rd[0], rm[0], cnt[0]);
    end
    checks++;
`ifdef MMIO_TRACE_TS_EN
    if (rt[0] !== t0) begin
`else
    if (rt[0] !== 16'h0) begin
`endif
      errors++;
      $display("FAIL basic_ts got %h (capture-cycle counter %h)", rt[0], t0);
    end
    rdy = 1'b1;
    cycle();
    rdy = 1'b0;
    checks++;
    if ({v[0], cnt[0], rd[0]} !== '0) begin
      errors++;
      $display("FAIL basic_pop got v=%b cnt=%0d data=%h required 0/0/0", v[0], cnt[0], rd[0]);
    end
  endtask

  task automatic test_filter();
    logic [29:0] wa [4] = '{30'hFF, 30'h100, 30'h1FF, 30'h200};
    apply_reset();
    foreach (wa[k]) wr(wa[k], 32'(wa[k]), 4'hF);
    wr(30'h180, 32'h180, 4'h0);
    checks++;
    if (cnt[2] !== 3'd2 || ra[2] !== 30'h100) begin
      errors++;
      $display("FAIL filter_first got cnt=%0d addr=%h required 2/100", cnt[2], ra[2]);
    end
    rdy = 1'b1;
    cycle();
    checks++;
    if (ra[2] !== 30'h1FF || v[2] !== 1'b1) begin
      errors++;
      $display("FAIL filter_second got v=%b addr=%h required 1/1ff", v[2], ra[2]);
    end
    cycle();
    rdy = 1'b0;
    checks++;
    if (v[2] !== 1'b0) begin
      errors++;
      $display("FAIL filter_empty got v=%b required 0", v[2]);
    end
  endtask

  task automatic test_full_modes();
    logic [15:0] prev;
    apply_reset();
    for (int k = 1; k <= 6; k++) wr(30'h150, 32'(k), 4'hF);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (full[i] !== 1'b1 || drp[i] !== 16'd2 || cnt[i] !== 3'd4) begin
        errors++;
        $display("FAIL full_state inst=%0d got full=%b drop=%0d cnt=%0d required 1/2/4", i, full[i], drp[i], cnt[i]);
      end
    end
    prev = 16'h0;
    rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd[0] !== 32'(k + 1) || rd[1] !== 32'(k + 3)) begin
        errors++;
        $display("FAIL full_drain slot=%0d got stop=%0d ovw=%0d required %0d/%0d", k, rd[0], rd[1], k + 1, k + 3);
      end
`ifdef MMIO_TRACE_TS_EN
      if (k > 0) begin
        checks++;
        if (rt[1] !== prev + 16'h1) begin
          errors++;
          $display("FAIL ovw_ts slot=%0d got %h required %h", k, rt[1], prev + 16'h1);
        end
      end
`else
      checks++;
      if (rt[1] !== 16'h0) begin
        errors++;
        $display("FAIL ovw_ts slot=%0d got %h required 0", k, rt[1]);
      end
`endif
      prev = rt[1];
      cycle();
    end
    rdy = 1'b0;
  endtask

  task automatic test_push_pop_full();
    int exp_d [4] = '{2, 3, 4, 7};
    apply_reset();
    for (int k = 1; k <= 4; k++) wr(30'h20, 32'(k), 4'h3);
    rdy = 1'b1;
    wr(30'h20, 32'd7, 4'h3);
    checks++;
    if (cnt[0] !== 3'd4 || drp[0] !== 16'd0) begin
      errors++;
      $display("FAIL pushpop_full got cnt=%0d drop=%0d required 4/0", cnt[0], drp[0]);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd[0] !== 32'(exp_d[k])) begin
        errors++;
        $display("FAIL pushpop_drain slot=%0d got %0d required %0d", k, rd[0], exp_d[k]);
      end
      cycle();
    end
    rdy = 1'b0;
  endtask

  task automatic test_enable();
    apply_reset();
    en = 1'b0;
    for (int k = 0; k < 6; k++) wr(30'h150, 32'(k), 4'hF);
    checks++;
    if (cnt[0] !== 3'd0 || drp[0] !== 16'd0 || v[2] !== 1'b0) begin
      errors++;
      $display("FAIL enable_off got cnt=%0d drop=%0d win_v=%b required 0/0/0", cnt[0], drp[0], v[2]);
    end
    en = 1'b1;
  endtask

  task automatic test_clear_reset();
    apply_reset();
    for (int k = 0; k < 6; k++) wr(30'h40, 32'(k), 4'hF);
    clr = 1'b1;
    wr(30'h40, 32'd9, 4'hF);
    clr = 1'b0;
    checks++;
    if (cnt[0] !== 3'd0 || drp[0] !== 16'd0 || v[0] !== 1'b0 || cnt[1] !== 3'd0) begin
      errors++;
      $display("FAIL clear got cnt=%0d drop=%0d v=%b ovw_cnt=%0d required 0/0/0/0", cnt[0], drp[0], v[0], cnt[1]);
    end
    wr(30'h41, 32'hA1, 4'hF);
    wr(30'h42, 32'hA2, 4'hF);
    rdy = 1'b1;
    cycle();
    checks++;
    if (v[0] !== 1'b1 || rd[0] !== 32'hA2) begin
      errors++;
      $display("FAIL drain_before_reset got v=%b data=%h required 1/a2", v[0], rd[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({v[0], cnt[0], rd[0], ra[0]} !== '0) begin
      errors++;
      $display("FAIL async_reset got v=%b cnt=%0d data=%h addr=%h required all zero", v[0], cnt[0], rd[0], ra[0]);
    end
    apply_reset();
  endtask

  task automatic test_random();
    rec_t er;
    logic [29:0] pick [5] = '{30'hFF, 30'h100, 30'h150, 30'h1FF, 30'h200};
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      addr = ($urandom_range(5, 0) == 5) ? 30'($urandom) : pick[$urandom_range(4, 0)];
      data = $urandom;
      mask = ($urandom_range(3, 0) == 0) ? 4'h0 : 4'($urandom);
      wren = ($urandom_range(9, 0) < 6);
      en   = ($urandom_range(9, 0) != 0);
      rdy  = ($urandom_range(9, 0) < 4);
      clr  = ($urandom_range(63, 0) == 0);
      cycle();
      for (int i = 0; i < N; i++) begin
        if (mq[i].size() != 0) er = mq[i][0];
        else er = '{a: '0, d: '0, m: '0, t: '0};
        checks++;
        if (v[i] !== (mq[i].size() != 0) || cnt[i] !== 3'(mq[i].size()) || full[i] !== (mq[i].size() == M_DEPTH)) begin
          errors++;
          $display("FAIL rnd_occupancy inst=%0d cyc=%0d got v=%b cnt=%0d full=%b required size %0d",
                   i, c, v[i], cnt[i], full[i], mq[i].size());
        end
        checks++;
        if (drp[i] !== 16'(mdrop[i])) begin
          errors++;
          $display("FAIL rnd_drop inst=%0d cyc=%0d got %0d required %0d", i, c, drp[i], mdrop[i]);
        end
        checks++;
        if (ra[i] !== er.a || rd[i] !== er.d || rm[i] !== er.m || rt[i] !== exp_ts(er)) begin
          errors++;
          $display("FAIL rnd_head inst=%0d cyc=%0d got %h/%h/%h/%h required %h/%h/%h/%h",
                   i, c, ra[i], rd[i], rm[i], rt[i], er.a, er.d, er.m, exp_ts(er));
        end
      end
    end
    wren = 1'b0; clr = 1'b0; rdy = 1'b0; en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_filter();
    test_full_modes();
    test_push_pop_full();
    test_enable();
    test_clear_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
